uart_tx_mmio: RTL

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_pkg.sv | 36 +++
 rtl/byte_fifo.sv | 58 +++++
 rtl/uart_tx_mmio.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
// Holds the FSM state encoding, register offsets and STATUS layout.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;

   localparam int STAT_BUSY = 0;
   localparam int STAT_FULL = 1;
   localparam int STAT_OVF  = 2;
   localparam int STAT_CNT  = 3;
   localparam int CNT_W     = 5;

   function automatic logic [31:0] pack_status(
      input logic             busy,
      input logic             full,
      input logic             ovf,
      input logic [CNT_W-1:0] cnt
   );
      logic [31:0] s;
      s                    = '0;
      s[STAT_BUSY]         = busy;
      s[STAT_FULL]         = full;
      s[STAT_OVF]          = ovf;
      s[STAT_CNT +: CNT_W] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous 8-bit FIFO, DEPTH a power of two.
// Ports: clk, resetn (sync, active-low), push/wdata, pop/rdata
// (head, combinational), full, empty, count.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    push,
   input  logic [7:0]              wdata,
   input  logic                    pop,
   output logic [7:0]              rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   // Full/empty come from the pre-edge count, so a push into a
   // full FIFO is dropped even when a pop happens on the same edge.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wptr <= wptr + AW'(1);
         if (do_pop)
            rptr <= rptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: 8N1 UART transmitter behind a two-register MMIO port.
// Ports: clk, resetn (sync, active-low); io_wr/io_rd/io_addr/io_wdata
// register access, io_rdata registered read data; txd serial out
// (idle high); busy = FIFO non-empty or frame in flight.
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        io_wr,
   input  logic        io_rd,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        txd,
   output logic        busy
);

   import uart_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST =
      16'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   tx_state_t     state_n;
   logic [15:0]   baud_cnt;
   logic [15:0]   baud_n;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_n;
   logic [7:0]    shreg;
   logic [7:0]    shreg_n;
   logic          txd_n;
   logic          baud_done;

   logic          ovf;
   logic          data_wr;
   logic          ovf_clr;
   logic          pop;
   logic [7:0]    head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [31:0]   status;
   logic          unused_wdata;

   // Strobes are qualified with resetn so nothing leaks in
   // during a reset cycle.
   assign data_wr = resetn && io_wr &&
                    (io_addr == ADDR_DATA);
   assign ovf_clr = resetn && io_wr &&
                    (io_addr == ADDR_STATUS) &&
                    io_wdata[STAT_OVF];
   assign unused_wdata = ^io_wdata[31:8];

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign busy      = (state != ST_IDLE) || !empty;
   assign status    = pack_status(busy, full, ovf,
                                  CNT_W'(count));

   byte_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (data_wr),
      .wdata  (io_wdata[7:0]),
      .pop    (pop),
      .rdata  (head),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         shreg    <= shreg_n;
         txd      <= txd_n;
      end
   end

   // Every transition zeroes the baud counter so bit timing is
   // re-anchored at each state change and cannot drift.
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt + 16'd1;
      bit_n   = bit_idx;
      shreg_n = shreg;
      pop     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            baud_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = head;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (baud_done) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               baud_n  = '0;
               shreg_n = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7)
                  state_n = ST_STOP;
               else
                  bit_n = bit_idx + 3'd1;
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               baud_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = head;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // txd is registered from the next state so the line
      // changes exactly on the transition edge.
      txd_n = 1'b1;
      if (state_n == ST_START)
         txd_n = 1'b0;
      else if (state_n == ST_DATA)
         txd_n = shreg_n[0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ovf      <= 1'b0;
         io_rdata <= '0;
      end else begin
         // A new overflow wins over a clear on the same edge.
         if (data_wr && full)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
         if (io_rd)
            io_rdata <= (io_addr == ADDR_STATUS) ?
                        status : 32'd0;
      end
   end

endmodule
